// File: rtl/fwd_scoreboard_if.sv
// Issue/source/forwarding bundle between the ID stage and fwd_scoreboard.
// stall_count exists only when FWD_STALL_COUNT_EN is defined.
interface fwd_scoreboard_if #(
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 3
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic                    issue_we;
    logic [4:0]              issue_waddr;
    logic                    issue_is_load;
    logic                    issue_is_md;
    logic                    issue_reads_hilo;
    logic                    flush;
    logic [NUM_SRC*5-1:0]    src_addr;
    logic [NUM_SRC-1:0]      src_used;
    logic [NUM_SRC-1:0]      src_early;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall;
    logic                    md_busy;
`ifdef FWD_STALL_COUNT_EN
    logic [31:0]             stall_count;

    modport master (
        output issue_we, issue_waddr, issue_is_load, issue_is_md, issue_reads_hilo, flush,
        output src_addr, src_used, src_early,
        input  fwd_sel, stall, md_busy, stall_count
    );
    modport slave (
        input  issue_we, issue_waddr, issue_is_load, issue_is_md, issue_reads_hilo, flush,
        input  src_addr, src_used, src_early,
        output fwd_sel, stall, md_busy, stall_count
    );
`else
    modport master (
        output issue_we, issue_waddr, issue_is_load, issue_is_md, issue_reads_hilo, flush,
        output src_addr, src_used, src_early,
        input  fwd_sel, stall, md_busy
    );
    modport slave (
        input  issue_we, issue_waddr, issue_is_load, issue_is_md, issue_reads_hilo, flush,
        input  src_addr, src_used, src_early,
        output fwd_sel, stall, md_busy
    );
`endif
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit with a shadow pipeline of in-flight destinations and a mul/div busy countdown.
// Optional macro FWD_STALL_COUNT_EN adds a saturating 32-bit stall counter.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 3,
    parameter int MD_LATENCY = 8,
    parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic           clk,
    input  logic           reset,
    fwd_scoreboard_if.slave bus
);
    localparam int MDW = $clog2(MD_LATENCY + 1);

    logic [FWD_STAGES-1:0] r_v;
    logic [FWD_STAGES-1:0] r_we;
    logic [FWD_STAGES-1:0] r_load;
    logic [4:0]            r_addr [FWD_STAGES];
    logic [MDW-1:0]        r_md_cnt;

    logic [NUM_SRC-1:0]    w_port_stall;
    logic                  w_md_busy;
    logic                  w_stall;
    logic                  w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_port
            logic [4:0]      w_src;
            logic [SELW-1:0] w_sel;
            logic            w_sel_load;

            assign w_src = bus.src_addr[gi*5 +: 5];

            // Scan oldest to youngest so the youngest matching producer wins.
            always_comb begin
                w_sel      = '0;
                w_sel_load = 1'b0;
                for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                    if (bus.src_used[gi] && r_v[k] && r_we[k] &&
                        (r_addr[k] == w_src) && (w_src != 5'd0)) begin
                        w_sel      = SELW'(k + 1);
                        w_sel_load = r_load[k];
                    end
                end
            end

            assign w_port_stall[gi] = bus.src_early[gi]
                ? ((w_sel == SELW'(1)) || ((w_sel == SELW'(2)) && w_sel_load))
                : ((w_sel == SELW'(1)) && w_sel_load);

            assign bus.fwd_sel[gi*SELW +: SELW] = w_sel;
        end
    endgenerate

    assign w_md_busy = (r_md_cnt != '0);
    // A second mul/div issue is held off until the current one drains.
    assign w_stall   = (|w_port_stall) ||
                       ((bus.issue_reads_hilo || bus.issue_is_md) && w_md_busy);
    assign w_accept  = !w_stall && !bus.flush;

    assign bus.stall   = w_stall;
    assign bus.md_busy = w_md_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v    <= '0;
            r_we   <= '0;
            r_load <= '0;
            for (int k = 0; k < FWD_STAGES; k++) begin
                r_addr[k] <= '0;
            end
        end else begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
                r_v[k]    <= r_v[k-1];
                r_we[k]   <= r_we[k-1];
                r_load[k] <= r_load[k-1];
                r_addr[k] <= r_addr[k-1];
            end
            r_v[0]    <= w_accept;
            r_we[0]   <= bus.issue_we;
            r_load[0] <= bus.issue_is_load;
            r_addr[0] <= bus.issue_waddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_accept && bus.issue_is_md) begin
            r_md_cnt <= MDW'(MD_LATENCY);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MDW'(1);
        end
    end

`ifdef FWD_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && !bus.flush && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench: a cycle-history reference model predicts outputs, a monitor compares them.
module tb_fwd_scoreboard;
    localparam int NS  = 3;
    localparam int FS  = 3;
    localparam int MDL = 8;
    localparam int SW  = $clog2(FS + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    fwd_scoreboard_if #(.NUM_SRC(NS), .FWD_STAGES(FS)) bus ();

    fwd_scoreboard #(.NUM_SRC(NS), .FWD_STAGES(FS), .MD_LATENCY(MDL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NS*SW-1:0] sel;
        logic             stall;
        logic             busy;
        logic [31:0]      cnt;
    } exp_t;

    typedef struct packed {
        logic          we;
        logic [4:0]    wa;
        logic          ld;
        logic          md;
        logic          hilo;
        logic          fl;
        logic [NS*5-1:0] sa;
        logic [NS-1:0] used;
        logic [NS-1:0] early;
    } ins_t;

    exp_t exp_q[$];
    ins_t prog_q[$];
    exp_t e_mon;
    ins_t cur;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what was accepted in each cycle, plus when the last mul/div was accepted.
    int   cyc = 0;
    int   reset_cyc = 0;
    int   last_md = -1000;
    bit   hv [8192];
    bit   hwe[8192];
    bit   hld[8192];
    logic [4:0] had[8192];
    logic [31:0] m_cnt = 32'd0;
    bit   prev_hold = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endfunction

    // Stage k in cycle c holds whatever was accepted in cycle c-1-k (since the last reset).
    function automatic exp_t model_eval();
        exp_t e;
        e = '0;
        for (int i = 0; i < NS; i++) begin
            logic [4:0] a;
            int hit;
            bit hl;
            a   = bus.src_addr[i*5 +: 5];
            hit = 0;
            hl  = 1'b0;
            if (bus.src_used[i] && a != 5'd0) begin
                for (int k = 0; k < FS; k++) begin
                    int t;
                    t = cyc - 1 - k;
                    if (hit == 0 && t >= reset_cyc && hv[t] && hwe[t] && had[t] == a) begin
                        hit = k + 1;
                        hl  = hld[t];
                    end
                end
            end
            e.sel[i*SW +: SW] = SW'(hit);
            if (bus.src_early[i]) begin
                if (hit == 1 || (hit == 2 && hl)) e.stall = 1'b1;
            end else if (hit == 1 && hl) begin
                e.stall = 1'b1;
            end
        end
        e.busy = (last_md >= reset_cyc) && (cyc - last_md >= 1) && (cyc - last_md <= MDL);
        if ((bus.issue_reads_hilo || bus.issue_is_md) && e.busy) e.stall = 1'b1;
        e.cnt = m_cnt;
        return e;
    endfunction

    function automatic ins_t mk(bit we, int wa, bit ld, bit md, bit hilo, bit fl,
                                int s0, int s1, int s2, bit [2:0] used, bit [2:0] early);
        ins_t r;
        r.we    = we;
        r.wa    = 5'(wa);
        r.ld    = ld;
        r.md    = md;
        r.hilo  = hilo;
        r.fl    = fl;
        r.sa    = {5'(s2), 5'(s1), 5'(s0)};
        r.used  = used;
        r.early = early;
        return r;
    endfunction

    function automatic int pick();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 5;
            2:       return 8;
            3:       return 9;
            4:       return 31;
            default: return int'($urandom_range(1, 31));
        endcase
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom_range(0, 3) != 0, pick(), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, pick(), pick(), pick(),
                  3'($urandom_range(0, 7)),
                  {1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)});
    endfunction

    task automatic apply(input ins_t c);
        bus.issue_we         = c.we;
        bus.issue_waddr      = c.wa;
        bus.issue_is_load    = c.ld;
        bus.issue_is_md      = c.md;
        bus.issue_reads_hilo = c.hilo;
        bus.flush            = c.fl;
        bus.src_addr         = c.sa;
        bus.src_used         = c.used;
        bus.src_early        = c.early;
    endtask

    task automatic commit();
        exp_t e;
        @(posedge clk);
        e = model_eval();
        hv[cyc]  = !e.stall && !bus.flush;
        hwe[cyc] = bus.issue_we;
        had[cyc] = bus.issue_waddr;
        hld[cyc] = bus.issue_is_load;
        if (hv[cyc] && bus.issue_is_md) last_md = cyc;
        if (e.stall && !bus.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        prev_hold = e.stall && !bus.flush;
        cyc++;
    endtask

    // A stalled instruction stays in ID; otherwise the next one is fetched.
    task automatic run_cycle(input bit do_reset);
        @(negedge clk);
        if (!prev_hold) begin
            if (prog_q.size() > 0) cur = prog_q.pop_front();
            else cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000);
        end
        apply(cur);
        #1;
        exp_q.push_back(model_eval());
        if (do_reset) begin
            #2;
            chk("pre_reset_stall", 64'(bus.stall), 64'd1);
            reset = 1'b1;
            #1;
            chk("reset_fwd_sel", 64'(bus.fwd_sel), 64'd0);
            chk("reset_stall", 64'(bus.stall), 64'd0);
            chk("reset_md_busy", 64'(bus.md_busy), 64'd0);
`ifdef FWD_STALL_COUNT_EN
            chk("reset_stall_count", 64'(bus.stall_count), 64'd0);
`endif
            #1;
            reset     = 1'b0;
            reset_cyc = cyc;
            m_cnt     = 32'd0;
        end
        commit();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                chk("fwd_sel", 64'(bus.fwd_sel), 64'(e_mon.sel));
                chk("stall", 64'(bus.stall), 64'(e_mon.stall));
                chk("md_busy", 64'(bus.md_busy), 64'(e_mon.busy));
`ifdef FWD_STALL_COUNT_EN
                chk("stall_count", 64'(bus.stall_count), 64'(e_mon.cnt));
`endif
            end
        end
    end

    initial begin
        int guard;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        repeat (2) @(posedge clk);
        #1;
        chk("init_fwd_sel", 64'(bus.fwd_sel), 64'd0);
        chk("init_stall", 64'(bus.stall), 64'd0);
        chk("init_md_busy", 64'(bus.md_busy), 64'd0);
        #1;
        reset = 1'b0;

        // Directed program: ALU chain, load-use, jr early, $0, priority, mul/div.
        prog_q.push_back(mk(1, 8, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(1, 2, 0, 0, 0, 0, 8, 0, 0, 3'b001, 3'b000));
        prog_q.push_back(mk(1, 3, 0, 0, 0, 0, 8, 0, 0, 3'b001, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 3'b001, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 8, 0, 0, 3'b001, 3'b000));
        prog_q.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 3'b001, 3'b000));
        prog_q.push_back(mk(1, 31, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 3'b100, 3'b100));
        prog_q.push_back(mk(1, 31, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 3'b100, 3'b100));
        prog_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111, 3'b110));
        prog_q.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5, 0, 3'b011, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(1, 4, 0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b000));
        guard = 0;
        while ((prog_q.size() > 0 || prev_hold) && guard < 300) begin
            run_cycle(1'b0);
            guard++;
        end
        if (guard >= 300) chk("directed_drain_timeout", 64'(guard), 64'd0);

        // Load-use stall interrupted by reset.
        prog_q.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));
        prog_q.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0, 3'b001, 3'b000));
        run_cycle(1'b0);
        run_cycle(1'b1);

        for (int n = 0; n < 3000; n++) begin
            if (prog_q.size() == 0) prog_q.push_back(rnd_ins());
            run_cycle(1'b0);
        end

        repeat (2) @(negedge clk);
        #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined MIPS core; successor to the fixed EX/MEM/WB forwarding logic.
- Keeps an internal shadow pipeline of in-flight destination registers, so the core no longer routes per-stage write addresses into the unit.
- Serves NUM_SRC read ports of the instruction in ID, each either late (consumed in EX) or early (consumed in ID, e.g. jr or branch compare).
- Outputs per-port forward selects, a unified stall, and a busy countdown for the multi-cycle mul/div unit.

Parameters:
- NUM_SRC, 3, number of source ports (default covers Rs, Rt, Jr).
- FWD_STAGES, 3, in-flight stages tracked; stage 0 = EX, 1 = MEM, 2 = WB, and so on.
- MD_LATENCY, 8, cycles the mul/div unit stays busy after issue; must be at least 1.
- SELW, $clog2(FWD_STAGES+1), width of one forward select (derived).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- issue_we  in  1  the ID instruction writes a GPR.
- issue_waddr  in  5  destination GPR of the ID instruction.
- issue_is_load  in  1  the ID instruction is a load (result available at the end of MEM).
- issue_is_md  in  1  the ID instruction starts the mul/div unit.
- issue_reads_hilo  in  1  the ID instruction is mfhi or mflo.
- flush  in  1  squash the ID instruction (it does not enter EX).
- src_addr  in  NUM_SRC*5  source GPR per port; port i occupies bits [5i+4:5i].
- src_used  in  NUM_SRC  port i is live.
- src_early  in  NUM_SRC  port i is consumed in ID rather than EX.
- fwd_sel  out  NUM_SRC*SELW  per port: 0 = register file, s = producer currently in stage s-1.
- stall  out  1  hold IF/ID; insert a bubble into EX.
- md_busy  out  1  mul/div countdown is non-zero.

Behaviour:
- State: FWD_STAGES entries {v, we, addr, load}, plus md_cnt of width $clog2(MD_LATENCY+1).
- Async reset: all entries have v=0; md_cnt=0. Resulting outputs: fwd_sel=0, stall=0, md_busy=0.
- Every posedge, entries k=1..FWD_STAGES-1 take entry k-1 unconditionally; the oldest entry retires.
- Entry 0 loads {1, issue_we, issue_waddr, issue_is_load} when accept = !stall && !flush. Otherwise it loads a bubble (v=0).
- Match(i,k) = src_used[i] && entry k is v && we && addr == src_addr[i] && src_addr[i] != 0.
- Register $0 never matches and never forwards.
- fwd_sel[i] is combinational: k+1 for the smallest k with Match(i,k), otherwise 0. The youngest producer wins; duplicate writers in older stages are ignored.
- Late port stall condition: the selected producer is at k=0 and is a load (load-use).
- Early port stall conditions:
  - the selected producer is at k=0 (any op); or
  - the selected producer is at k=1 and is a load.
- HI/LO stall condition: issue_reads_hilo && md_busy.
- stall = OR of all late-port, early-port and HI/LO conditions.
- A stall is re-evaluated each cycle. The stalled instruction stays in ID, and bubbles propagate until the condition clears.
- md_cnt:
  - loads MD_LATENCY on an accepted issue_is_md;
  - otherwise decrements while non-zero, saturating at 0;
  - md_busy = (md_cnt != 0).
  - A new md issue while busy is held off: issue_is_md && md_busy adds a stall, so it is never accepted mid-count.
- Flush: no entry is created and md_cnt is not loaded. Entries already in flight are unaffected. stall is still computed but is ignored by the core that cycle.
- Simultaneous flush and stall: a bubble is inserted (same as either alone).
- Reset mid-operation: all pending producers are dropped immediately, forwarding stops, and md_busy deasserts asynchronously.

Optional Feature:
- Macro: FWD_STALL_COUNT_EN.
- When defined:
  - adds output stall_count (32 bits), reset to 0;
  - increments on each posedge with stall=1 && !flush;
  - saturates at 32'hFFFFFFFF, with no wrap.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Back-to-back ALU dependence:
  - Stimulus: issue add $8 (accepted); next cycle the ID instruction has src0=$8 (late).
  - Required: fwd_sel[0]=1, stall=0. One cycle later, with an unrelated instruction issued, a fresh reader of $8 gets fwd_sel=2; the cycle after that, fwd_sel=3; then 0.
- Load-use:
  - Stimulus: issue lw $9; the next ID instruction reads $9 (late).
  - Required: stall=1 for exactly one cycle, then fwd_sel=2, stall=0.
- Early jr:
  - Stimulus: add $31 issued; the next ID instruction is jr $31 (src2 early).
  - Required: stall=1 for one cycle, then fwd_sel[2]=2.
  - Variant: with lw $31 instead, stall=1 for two cycles, then fwd_sel[2]=3.
- Zero register and priority:
  - Stimulus: writes to $0 in flight → fwd_sel=0 and no stall.
  - Stimulus: $5 written at stages 1 and 2 → fwd_sel=2 (the youngest producer).
- Mul/div with MD_LATENCY=8:
  - Stimulus: accepted mult, then mfhi in ID.
  - Required: stall=1 for 8 cycles, md_busy falls after the 8th edge, and mfhi is accepted on the next edge.
  - With flush asserted during the mult issue: md_busy stays 0.
- Reset during a load-use stall:
  - Required: stall=0, fwd_sel=0 and md_busy=0 immediately; with FWD_STALL_COUNT_EN, stall_count=0.
